// File: rtl/nn_mlp_sequencer.sv
// Issue and writeback controller driving one shared half-precision MAC through the 784-50-10 MLP.
// Layer 1 must fully drain into the hidden buffer before any layer-2 operation is issued.
module nn_mlp_sequencer #(
    parameter int LAYER1_NEURONS = 784,
    parameter int LAYER2_NEURONS = 50,
    parameter int OUTPUT_NODES   = 10,
    localparam int RW = $clog2(LAYER1_NEURONS),
    localparam int CW = $clog2(LAYER2_NEURONS),
    localparam int OW = $clog2(OUTPUT_NODES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          op_valid,
    input  logic          mac_ready,
    output logic          op_first,
    output logic          op_last,
    output logic [1:0]    w_bank,
    output logic [RW-1:0] w_row,
    output logic [CW-1:0] w_col,
    output logic          x_sel,
    output logic [RW-1:0] x_addr,
    input  logic          res_valid,
    output logic          hid_we,
    output logic [CW-1:0] hid_addr,
    output logic          out_we,
    output logic [OW-1:0] out_addr
);

    typedef enum logic [2:0] {
        IDLE,
        L1_ISSUE,
        L1_DRAIN,
        L2_ISSUE,
        L2_DRAIN,
        FIN
    } state_t;

    localparam logic [RW-1:0] L1_ROW_MAX = RW'(LAYER1_NEURONS - 1);
    localparam logic [RW-1:0] L2_ROW_MAX = RW'(LAYER2_NEURONS - 1);
    localparam logic [CW-1:0] L1_COL_MAX = CW'(LAYER2_NEURONS - 1);
    localparam logic [CW-1:0] L2_COL_MAX = CW'(OUTPUT_NODES - 1);
    localparam logic [CW:0]   HID_TOTAL  = (CW+1)'(LAYER2_NEURONS);
    localparam logic [OW:0]   OUT_TOTAL  = (OW+1)'(OUTPUT_NODES);

    state_t        state, state_nxt;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          in_prod;
    logic [CW:0]   outstanding;
    logic [CW:0]   hid_cnt;
    logic [OW:0]   out_cnt;

    logic          issuing, in_l2, hs, row_end, layer_end, issue_last;
    logic          res_take, hid_full, out_full;
    logic [RW-1:0] row_max;
    logic [CW-1:0] col_max;

    // in_prod=0 means the next op for the current neuron/node is its bias load
    assign issuing    = (state == L1_ISSUE) || (state == L2_ISSUE);
    assign in_l2      = (state == L2_ISSUE);
    assign row_max    = in_l2 ? L2_ROW_MAX : L1_ROW_MAX;
    assign col_max    = in_l2 ? L2_COL_MAX : L1_COL_MAX;
    assign hs         = issuing && mac_ready;
    assign row_end    = in_prod && (row == row_max);
    assign layer_end  = row_end && (col == col_max);
    assign issue_last = hs && row_end;

    // Results arriving with nothing in flight are protocol errors and are dropped
    assign res_take = res_valid && (outstanding != '0);
    assign hid_full = (hid_cnt == HID_TOTAL);
    assign out_full = (out_cnt == OUT_TOTAL);
    assign hid_we   = res_take && !hid_full;
    assign out_we   = res_take && hid_full && !out_full;
    assign hid_addr = hid_cnt[CW-1:0];
    assign out_addr = out_cnt[OW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == FIN);
        op_valid  = issuing;
        op_first  = issuing && !in_prod;
        op_last   = issuing && row_end;
        w_bank    = issuing ? {in_l2, !in_prod} : 2'b00;
        w_row     = row;
        w_col     = col;
        x_sel     = in_l2;
        x_addr    = row;
        case (state)
            IDLE:     if (start) state_nxt = L1_ISSUE;
            L1_ISSUE: if (hs && layer_end) state_nxt = L1_DRAIN;
            L1_DRAIN: if ((outstanding == '0) && hid_full) state_nxt = L2_ISSUE;
            L2_ISSUE: if (hs && layer_end) state_nxt = L2_DRAIN;
            L2_DRAIN: if (out_full) state_nxt = FIN;
            FIN:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Issue counters only move on a handshake, so a stalled op holds every field
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row         <= '0;
            col         <= '0;
            in_prod     <= 1'b0;
            outstanding <= '0;
            hid_cnt     <= '0;
            out_cnt     <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                row     <= '0;
                col     <= '0;
                in_prod <= 1'b0;
                hid_cnt <= '0;
                out_cnt <= '0;
            end
            if (hs) begin
                if (!in_prod) begin
                    in_prod <= 1'b1;
                    row     <= '0;
                end else if (row == row_max) begin
                    in_prod <= 1'b0;
                    row     <= '0;
                    col     <= (col == col_max) ? '0 : col + CW'(1);
                end else begin
                    row <= row + RW'(1);
                end
            end
            if (issue_last && !res_take) begin
                outstanding <= outstanding + (CW+1)'(1);
            end else if (res_take && !issue_last) begin
                outstanding <= outstanding - (CW+1)'(1);
            end
            if (hid_we) hid_cnt <= hid_cnt + (CW+1)'(1);
            if (out_we) out_cnt <= out_cnt + (OW+1)'(1);
        end
    end

endmodule

// File: tb/tb_nn_mlp_sequencer.sv
// Directed bench for nn_mlp_sequencer: a fixed-latency datapath model, an op-stream
// reference model, mid-layer reset, stalled handshakes and ignored start/result pulses.
module tb_nn_mlp_sequencer;

    localparam int N1  = 784;
    localparam int N2  = 50;
    localparam int N3  = 10;
    localparam int RW  = 10;
    localparam int CW  = 6;
    localparam int OW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, op_valid, mac_ready, op_first, op_last;
    logic [1:0]    w_bank;
    logic [RW-1:0] w_row, x_addr;
    logic [CW-1:0] w_col, hid_addr;
    logic          x_sel, res_valid, hid_we, out_we;
    logic [OW-1:0] out_addr;

    always #5 clk = ~clk;

    nn_mlp_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .op_valid(op_valid), .mac_ready(mac_ready), .op_first(op_first), .op_last(op_last),
        .w_bank(w_bank), .w_row(w_row), .w_col(w_col), .x_sel(x_sel), .x_addr(x_addr),
        .res_valid(res_valid), .hid_we(hid_we), .hid_addr(hid_addr),
        .out_we(out_we), .out_addr(out_addr)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model of the op stream and of the writeback bookkeeping
    int m_layer, m_bias, m_row, m_col, m_out;
    int hid_writes, out_writes, l1_hs, l2_hs, done_count;
    int start_cyc, hid_done_cyc, out_done_cyc;
    int lat;
    bit rand_ready;
    logic [127:0] pipe;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
        end
        if (bad >= 20) begin
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_op_valid", op_valid, 0);
        checkOutput("rst_op_first", op_first, 0);
        checkOutput("rst_op_last", op_last, 0);
        checkOutput("rst_w_bank", w_bank, 0);
        checkOutput("rst_w_row", w_row, 0);
        checkOutput("rst_w_col", w_col, 0);
        checkOutput("rst_x_sel", x_sel, 0);
        checkOutput("rst_x_addr", x_addr, 0);
        checkOutput("rst_hid_we", hid_we, 0);
        checkOutput("rst_hid_addr", hid_addr, 0);
        checkOutput("rst_out_we", out_we, 0);
        checkOutput("rst_out_addr", out_addr, 0);
    endtask

    task automatic clearModel();
        m_layer = 0; m_bias = 1; m_row = 0; m_col = 0; m_out = 0;
        hid_writes = 0; out_writes = 0; l1_hs = 0; l2_hs = 0; done_count = 0;
        start_cyc = -1; hid_done_cyc = -1; out_done_cyc = -1;
    endtask

    // One clock cycle: entered and left at posedge+1
    task automatic applyStimulus(input bit drive_start, input bit spurious);
        bit exp_valid, exp_busy, exp_done, hs, e_last, res_take, exp_hid, exp_out;
        int n, cmax;
        mac_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
        res_valid = pipe[lat-1] | spurious;
        start     = drive_start;
        #1;
        n    = (m_layer == 2) ? N2 : N1;
        cmax = (m_layer == 2) ? N3 - 1 : N2 - 1;
        exp_valid = (m_layer == 1) || (m_layer == 2 && hid_done_cyc >= 0 && cyc >= hid_done_cyc + 2);
        exp_busy  = (m_layer != 0) && !(out_done_cyc >= 0 && cyc > out_done_cyc + 2);
        exp_done  = (out_done_cyc >= 0) && (cyc == out_done_cyc + 2);
        e_last    = (m_bias == 0) && (m_row == n - 1);
        checkOutput("op_valid", op_valid, exp_valid);
        checkOutput("busy", busy, exp_busy);
        checkOutput("done", done, exp_done);
        if (op_valid && exp_valid) begin
            checkOutput("op_first", op_first, m_bias);
            checkOutput("op_last", op_last, e_last);
            checkOutput("w_bank", w_bank, (m_layer == 2 ? 2 : 0) + m_bias);
            checkOutput("w_row", w_row, m_row);
            checkOutput("x_addr", x_addr, m_row);
            checkOutput("w_col", w_col, m_col);
            checkOutput("x_sel", x_sel, (m_layer == 2) ? 1 : 0);
        end
        hs       = exp_valid && mac_ready;
        res_take = res_valid && (m_out > 0);
        exp_hid  = res_take && (hid_writes < N2);
        exp_out  = res_take && (hid_writes == N2) && (out_writes < N3);
        checkOutput("hid_we", hid_we, exp_hid);
        checkOutput("out_we", out_we, exp_out);
        if (exp_hid) checkOutput("hid_addr", hid_addr, hid_writes);
        if (exp_out) checkOutput("out_addr", out_addr, out_writes);
        if (done) done_count++;
        if (hs) begin
            if (m_layer == 1) l1_hs++; else l2_hs++;
            if (m_bias == 1) begin
                m_bias = 0; m_row = 0;
            end else if (m_row == n - 1) begin
                m_row = 0; m_bias = 1;
                if (m_col == cmax) begin m_col = 0; m_layer++; end
                else m_col++;
            end else begin
                m_row++;
            end
        end
        pipe  = {pipe[126:0], hs && e_last};
        m_out = m_out + ((hs && e_last) ? 1 : 0) - (res_take ? 1 : 0);
        if (exp_hid) begin
            hid_writes++;
            if (hid_writes == N2) hid_done_cyc = cyc;
        end
        if (exp_out) begin
            out_writes++;
            if (out_writes == N3) out_done_cyc = cyc;
        end
        if (drive_start && m_layer == 0) begin
            m_layer = 1; m_bias = 1; m_row = 0; m_col = 0; start_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int guard;
        start = 1'b0; mac_ready = 1'b0; res_valid = 1'b0;
        lat = 4; pipe = '0; rand_ready = 1'b0;
        clearModel();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 checkResetOutputs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Run 1: 30% ready for the first two neurons, then reset at neuron 20
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        guard = 0;
        while (!(m_layer == 1 && m_col == 20 && m_bias == 1) && guard < 30000) begin
            rand_ready = (m_layer == 1 && m_col < 2);
            applyStimulus(cyc == start_cyc + 50, 1'b0);
            guard++;
        end
        rand_ready = 1'b0;
        checkOutput("run1_reached_neuron20", guard < 30000, 1);
        checkOutput("run1_l1_handshakes", l1_hs, 20 * 785);
        rst_n = 1'b0; res_valid = 1'b1;
        #1 checkResetOutputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc += 2;
        clearModel();
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b0);
        checkOutput("run1_no_done", done_count, 0);
        checkOutput("run1_no_stale_hid", hid_writes, 0);

        // Run 2: full inference, 100-cycle result latency, spurious start/results
        lat = 100; pipe = '0;
        clearModel();
        applyStimulus(1'b1, 1'b0);
        guard = 0;
        while (!(out_done_cyc >= 0 && cyc > out_done_cyc + 4) && guard < 45000) begin
            applyStimulus(cyc == start_cyc + 200,
                          (cyc == start_cyc + 5) || (hid_done_cyc >= 0 && cyc == hid_done_cyc + 1));
            guard++;
        end
        checkOutput("run2_completed", guard < 45000, 1);
        checkOutput("run2_l1_handshakes", l1_hs, 39250);
        checkOutput("run2_l2_handshakes", l2_hs, 510);
        checkOutput("run2_hid_writes", hid_writes, 50);
        checkOutput("run2_out_writes", out_writes, 10);
        checkOutput("run2_done_pulses", done_count, 1);
        checkOutput("run2_busy_after", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nn_mlp_sequencer.md
Name: nn_mlp_sequencer

Overview:
Control FSM that drives one shared half-precision MAC datapath through the 784-50-10 MLP. It runs layer 1 (b1, W1 against the input image), then layer 2 (b2, W2 against the hidden buffer). It issues one operation per handshake with weight and activation read addresses. It tracks results still in flight and steers datapath results into the hidden or output buffer. Layer 2 does not start until every layer-1 result has been written back.

Parameters:
LAYER1_NEURONS, 784, input activations per image (W1 rows)
LAYER2_NEURONS, 50, hidden neurons (W1 cols, W2 rows, b1 entries)
OUTPUT_NODES, 10, output nodes (W2 cols, b2 entries)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin inference; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the last output is written
op_valid  out  1  operation presented to the datapath
mac_ready  in  1  datapath accepts op; handshake = op_valid & mac_ready
op_first  out  1  bias op: datapath loads the bias into the accumulator, no x operand
op_last  out  1  final product for the current neuron/node
w_bank  out  2  0=W1, 1=b1, 2=W2, 3=b2
w_row  out  $clog2(LAYER1_NEURONS)  weight row (input index); 0 for bias ops
w_col  out  $clog2(LAYER2_NEURONS)  weight column / bias index (neuron or node)
x_sel  out  1  0=input image, 1=hidden buffer
x_addr  out  $clog2(LAYER1_NEURONS)  activation read address (equals w_row)
res_valid  in  1  datapath result available, in issue order
hid_we  out  1  combinational: res_valid while a layer-1 result is pending
hid_addr  out  $clog2(LAYER2_NEURONS)  hidden buffer write index
out_we  out  1  combinational: res_valid while a layer-2 result is pending
out_addr  out  $clog2(OUTPUT_NODES)  output buffer write index

Behaviour:
- Reset, asynchronous, any state: state=IDLE. busy, done, op_valid, op_first and op_last are 0. All address and index counters, the outstanding counter and the writeback counters are 0. Reset mid-inference abandons the inference with no done pulse. Any res_valid arriving after reset is ignored.
- States: IDLE, L1_ISSUE, L1_DRAIN, L2_ISSUE, L2_DRAIN, FIN.
- IDLE -> L1_ISSUE when start=1. op_valid rises on the following cycle. start is ignored in all other states.
- Issue sequence per neuron j (L1) or node k (L2):
  - One bias op: op_first=1, w_bank=b1 or b2, w_col=j or k, w_row=0.
  - Then one product op per input index i = 0..N-1: w_bank=W1 or W2, w_row=i, w_col=j or k, x_addr=i. op_last=1 only at i=N-1.
  - N = LAYER1_NEURONS in L1 and LAYER2_NEURONS in L2. x_sel=0 in L1, 1 in L2.
- Counters advance only on a handshake. With mac_ready=0, every op_* field holds stable.
- Issue totals: L1 = LAYER2_NEURONS*(LAYER1_NEURONS+1) = 39250 ops. L2 = OUTPUT_NODES*(LAYER2_NEURONS+1) = 510 ops.
- After the last L1 op handshake: state L1_DRAIN, op_valid=0. After the last L2 op handshake: state L2_DRAIN, op_valid=0.
- Outstanding counter:
  - +1 on an op_last handshake, -1 on res_valid.
  - Both in the same cycle leaves it unchanged.
  - res_valid while outstanding=0 is a protocol error: ignored, no counter change, no write enable.
- Writeback:
  - hid_we = res_valid while the layer-1 result count is below LAYER2_NEURONS. hid_addr = that count, incremented after each write.
  - After that, out_we and out_addr behave the same way against OUTPUT_NODES.
  - L1 results may arrive while still in L1_ISSUE and are handled normally.
- L1_DRAIN -> L2_ISSUE when outstanding=0 and all 50 hidden writes are done (registered decision).
- L2_DRAIN -> FIN when all 10 output writes are done. FIN asserts done=1 for one cycle, then IDLE with busy=0.
- Counters must not wrap mid-layer. i wraps to 0 only after op_last. j and k reset to 0 at the layer transition.

Test Plan:
- Bench datapath with fixed 4-cycle res_valid latency after op_last, mac_ready=1: pulse start -> exactly 39250 L1 and 510 L2 handshakes, 50 hid_we at hid_addr 0..49, 10 out_we at out_addr 0..9, exactly one done pulse, busy=0 afterwards.
- Sequence check: first L1 ops are (b1,row0,col0,first), (W1,0,0), ..., (W1,783,0,last), then (b1,row0,col1,first). First L2 op is (b2,row0,col0) with x_sel=1, issued only after hid_addr 49 has been written.
- Random mac_ready duty cycle of 30% -> identical op stream and counts to the ready=1 run, and all op fields stable whenever op_valid=1 & mac_ready=0.
- Delay every res_valid by 100 cycles -> state held in L1_DRAIN with no L2 op until the 50th hidden write, then L2 proceeds.
- Assert rst_n=0 mid-L1 at neuron 20 -> all outputs at reset values immediately. A new start gives a full run from (b1,0,0) with one done and no stale writes.
- start pulsed during busy, and res_valid with zero outstanding -> both ignored, and op counts and done timing unchanged.
